// File: rtl/acc_seq.sv
// Accumulator sequencer wrapped around an external combinational adder/subtractor.
// Commands in over valid/ready, accumulator results out with per-result and sticky overflow.
module acc_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             in_clr,
    output logic [WIDTH-1:0] add_dataa,
    output logic [WIDTH-1:0] add_datab,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        OUT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand;
    logic             op;
    logic             clr;

    logic             a_msb;
    logic             b_msb;
    logic             r_msb;
    logic             new_ovf;
    logic [WIDTH-1:0] acc_next;

    assign in_ready = (state == IDLE);

    // Adder inputs are registered copies, so these reflect exactly what the adder saw.
    assign a_msb = add_dataa[WIDTH-1];
    assign b_msb = add_datab[WIDTH-1];
    assign r_msb = add_result[WIDTH-1];

    always_comb begin
        new_ovf  = 1'b0;
        acc_next = add_result;
        if (clr) begin
            acc_next = operand;
        end else if (op) begin
            new_ovf = (a_msb == b_msb) && (r_msb != a_msb);
        end else begin
            new_ovf = (a_msb != b_msb) && (r_msb != a_msb);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            operand    <= '0;
            op         <= 1'b1;
            clr        <= 1'b0;
            add_dataa  <= '0;
            add_datab  <= '0;
            add_sub    <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand   <= in_data;
                        op        <= in_op;
                        clr       <= in_clr;
                        add_dataa <= acc;
                        add_datab <= in_data;
                        add_sub   <= in_op;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    acc       <= acc_next;
                    out_data  <= acc_next;
                    out_ovf   <= new_ovf;
                    out_valid <= 1'b1;
                    if (clr) begin
                        ovf_sticky <= new_ovf;
                    end else begin
                        ovf_sticky <= ovf_sticky | new_ovf;
                    end
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
